// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: status codes, icodes and register IDs.
package y86_pkg;

    typedef logic [3:0] reg_id_t;
    typedef logic [3:0] stat_t;
    typedef logic [3:0] icode_t;

    localparam reg_id_t RNONE = 4'hF;

    localparam stat_t SAOK = 4'h1;
    localparam stat_t SHLT = 4'h2;
    localparam stat_t SADR = 4'h3;
    localparam stat_t SINS = 4'h4;

    localparam icode_t IHALT   = 4'h0;
    localparam icode_t INOP    = 4'h1;
    localparam icode_t IRRMOVQ = 4'h2;
    localparam icode_t IIRMOVQ = 4'h3;
    localparam icode_t IRMMOVQ = 4'h4;
    localparam icode_t IMRMOVQ = 4'h5;
    localparam icode_t IOPQ    = 4'h6;
    localparam icode_t IJXX    = 4'h7;
    localparam icode_t ICALL   = 4'h8;
    localparam icode_t IRET    = 4'h9;
    localparam icode_t IPUSHQ  = 4'hA;
    localparam icode_t IPOPQ   = 4'hB;

    // Statuses that stop the machine; everything outside AOK and these is a bubble.
    function automatic logic stat_is_fault(input stat_t s);
        return (s == SHLT) || (s == SADR) || (s == SINS);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One decode read port: RNONE/out-of-range zeroing, plus a same-cycle
// commit bypass when REGFILE_BYPASS_EN is defined.
module regfile_rdport
    import y86_pkg::*;
#(
    parameter int NREGS = 15
) (
    input  reg_id_t     i_src,
    input  logic [63:0] i_regs [NREGS],
`ifdef REGFILE_BYPASS_EN
    input  logic        i_commit,
    input  reg_id_t     i_dstE,
    input  logic [63:0] i_valE,
    input  reg_id_t     i_dstM,
    input  logic [63:0] i_valM,
`endif
    output logic [63:0] o_rdata
);

    logic w_valid;

    assign w_valid = (i_src != RNONE) && (32'(i_src) < NREGS);

    always_comb begin
        o_rdata = '0;
        if (w_valid) begin
            o_rdata = i_regs[i_src];
`ifdef REGFILE_BYPASS_EN
            // M checked last so it overrides E, same as the write path
            if (i_commit && (i_dstE == i_src)) o_rdata = i_valE;
            if (i_commit && (i_dstM == i_src)) o_rdata = i_valM;
`endif
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Y86-64 register file and write-back commit point with sticky CPU status.
// Optional same-cycle read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_wb
    import y86_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  stat_t            W_stat,
    input  icode_t           W_icode,
    input  logic [63:0]      W_valE,
    input  logic [63:0]      W_valM,
    input  reg_id_t          W_dstE,
    input  reg_id_t          W_dstM,
    input  logic             W_stall,
    input  reg_id_t          d_srcA,
    input  reg_id_t          d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output stat_t            cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    logic [63:0]      r_regs [NREGS];
    stat_t            r_stat;
    logic             r_halted;
    logic [CNT_W-1:0] r_instret;

    logic w_commit;
    logic w_fault;
    logic w_we_e;
    logic w_we_m;
    logic w_count;

    assign w_commit = !rst && !W_stall && !r_halted && (W_stat == SAOK);
    assign w_fault  = !W_stall && !r_halted && stat_is_fault(W_stat);

    // On a shared destination only valM lands, as popq %rsp requires
    assign w_we_m  = w_commit && (W_dstM != RNONE);
    assign w_we_e  = w_commit && (W_dstE != RNONE) && (W_dstE != W_dstM);
    assign w_count = w_commit && (W_icode != INOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_we_m && (W_dstM == reg_id_t'(i)))
                    r_regs[i] <= W_valM;
                else if (w_we_e && (W_dstE == reg_id_t'(i)))
                    r_regs[i] <= W_valE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat   <= SAOK;
            r_halted <= 1'b0;
        end else if (w_fault) begin
            r_stat   <= W_stat;
            r_halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_instret <= '0;
        else if (w_count)
            r_instret <= r_instret + 1'b1;
    end

    regfile_rdport #(.NREGS(NREGS)) u_rdport_a (
        .i_src    (d_srcA),
        .i_regs   (r_regs),
`ifdef REGFILE_BYPASS_EN
        .i_commit (w_commit),
        .i_dstE   (W_dstE),
        .i_valE   (W_valE),
        .i_dstM   (W_dstM),
        .i_valM   (W_valM),
`endif
        .o_rdata  (d_rvalA)
    );

    regfile_rdport #(.NREGS(NREGS)) u_rdport_b (
        .i_src    (d_srcB),
        .i_regs   (r_regs),
`ifdef REGFILE_BYPASS_EN
        .i_commit (w_commit),
        .i_dstE   (W_dstE),
        .i_valE   (W_valE),
        .i_dstM   (W_dstM),
        .i_valM   (W_valM),
`endif
        .o_rdata  (d_rvalB)
    );

    assign cpu_stat = r_stat;
    assign halted   = r_halted;
    assign instret  = r_instret;

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Y86-64 register file and commit point, directly downstream of the write-back pipeline register. Consumes the W-stage bundle (stat, icode, valE/valM, dstE/dstM) and performs up to two register writes per cycle. Serves two combinational read ports to decode. Latches the architectural CPU status and freezes state on the first non-AOK instruction reaching write-back.

## Interface
Parameters:
- NREGS, 15, architectural registers, IDs 0..14; ID 15 is RNONE.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- W_stat  in  4  status of the instruction in write-back.
- W_icode  in  4  icode of the instruction in write-back.
- W_valE  in  64  ALU result, signed.
- W_valM  in  64  memory read value, signed.
- W_dstE  in  4  destination for valE; 15 means no write.
- W_dstM  in  4  destination for valM; 15 means no write.
- W_stall  in  1  write-back register held; suppresses commit this cycle.
- d_srcA  in  4  read port A register ID.
- d_srcB  in  4  read port B register ID.
- d_rvalA  out  64  read data A, combinational.
- d_rvalB  out  64  read data B, combinational.
- cpu_stat  out  4  architectural status, sticky.
- halted  out  1  high once a non-AOK status has committed.
- instret  out  CNT_W  count of retired instructions.

## Operation
- Status codes: AOK=1, HLT=2, ADR=3, INS=4. Any other value, including 0, is a bubble.
- commit = !rst && !W_stall && !halted && W_stat==AOK.
- On commit:
  - If W_dstE!=15, write W_valE to reg[W_dstE].
  - If W_dstM!=15, write W_valM to reg[W_dstM].
  - If W_dstE==W_dstM!=15, only valM is written; M wins, matching popq %rsp.
- instret increments on commit when W_icode!=INOP (1). Wraps modulo 2^CNT_W.
- Fault/halt entry: when !W_stall && !halted && W_stat∈{HLT,ADR,INS}:
  - cpu_stat<=W_stat and halted<=1.
  - No register write and no instret increment for that instruction.
- Bubble statuses (0, 5..15): no write, no count, no status change.
- Once halted: registers, instret and cpu_stat are frozen until rst. Reads remain live.
- Reads: d_rvalX = reg[d_srcX]. Reads of ID 15 return 0.

## Timing
- Write latency: committed data is visible in the array, and to reads without bypass, in the cycle after the commit edge.
- Read ports are purely combinational from the array (plus bypass when enabled). No read latency.
- Reset values: all reg[0..14]=0, cpu_stat=AOK, halted=0, instret=0. Outputs follow as d_rvalA=d_rvalB=0.
- rst has priority over commit and halt entry in the same cycle. rst mid-operation discards the in-flight write.
- Fault and W_stall in the same cycle: the fault is not latched until W_stall drops.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read of a register being committed this cycle returns the incoming value.
  - valM has priority over valE, matching write priority.
  - Bypass is gated by commit, so there is no bypass when stalled, halted or non-AOK.
- Undefined: reads return the stored array value only. Same-cycle write-read hazards are covered by decode forwarding.

## Structure
- Shared package y86_pkg holds:
  - stat codes SAOK/SHLT/SADR/SINS.
  - icode constants, including INOP and IHALT.
  - RNONE=4'hF and the register ID typedef.
- One sub-module, regfile_rdport: the ID-15 zeroing plus the optional bypass mux. Instantiated twice, for ports A and B.

## Test plan
- After rst, W_stat=1, W_dstE=3, W_valE=0x55, W_icode=6 → next cycle d_srcA=3 gives 0x55; instret=1.
- Same cycle W_dstE=W_dstM=4, valE=0x10, valM=0x20, stat AOK → reg4=0x20.
- W_stat=3 (ADR) with W_dstE=2, W_valE=0x99 → reg2 unchanged, cpu_stat=3, halted=1. Following AOK writes are ignored and instret is frozen.
- W_stall=1 for 3 cycles holding an AOK OPq writing reg5 → instret +1 only once, on release.
- With REGFILE_BYPASS_EN, commit reg7=0xABC while d_srcB=7 → d_rvalB=0xABC in the same cycle. Without the macro, d_rvalB shows the old value.
- d_srcA=15 → d_rvalA=0. rst asserted while halted → cpu_stat=1, halted=0, all registers 0.
